// File: rtl/sram_bus_arbiter_if.sv
// Pipeline-side request/response and external SRAM pins of the fetch/data SRAM arbiter.
// slave = arbiter view, master = pipeline + SRAM side.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 20
);
  // fetch path
  logic              if_ce;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  // MEM-stage load/store path
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              stall_req;
  // external SRAM pins
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              sram_wdata_oe;
  logic [31:0]       sram_rdata;

  modport slave (
    input  if_ce, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_valid, mem_rdata, mem_done, stall_req,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_wdata, sram_wdata_oe
  );

  modport master (
    output if_ce, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_valid, mem_rdata, mem_done, stall_req,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_wdata, sram_wdata_oe
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM port between fetch and data (data first); read WAIT_CYC+2, store WAIT_CYC+3 cycles
// from grant; stall_req held until served. FETCH_BUF_EN adds a one-entry fetch buffer.
module sram_bus_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, WR_HOLD, RESP} state_e;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC);

  state_e            state_q;
  logic [2:0]        wait_q;
  logic              owner_q;
  logic              is_wr_q;
  logic [31:0]       if_rdata_q;
  logic              if_valid_q;
  logic [31:0]       mem_rdata_q;
  logic              mem_done_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic [3:0]        be_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              wdata_oe_q;

  logic              acc_last;
  logic              buf_hit;
  logic [31:0]       buf_rdata;
  logic              unused_addr_bits;

  assign acc_last = (wait_q == WAIT_LAST);

  // Byte-offset and above-window address bits carry no meaning for the SRAM.
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0],
                              bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0]};

`ifdef FETCH_BUF_EN
  logic        buf_vld_q;
  logic [31:0] buf_addr_q;
  logic [31:0] buf_data_q;
  logic        store_grant;
  logic        fetch_fill;

  assign store_grant = (state_q == IDLE) && bus.mem_req && bus.mem_we;
  assign fetch_fill  = (state_q == ACC) && acc_last && !is_wr_q && !owner_q;
  assign buf_hit     = buf_vld_q && (bus.if_addr == buf_addr_q);
  assign buf_rdata   = buf_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else if (store_grant) begin
      buf_vld_q  <= 1'b0;
    end else if (fetch_fill) begin
      buf_vld_q  <= 1'b1;
      buf_addr_q <= bus.if_addr;
      buf_data_q <= bus.sram_rdata;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      owner_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      addr_q      <= '0;
      wdata_q     <= '0;
      wdata_oe_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mem_req) begin
            owner_q    <= 1'b1;
            is_wr_q    <= bus.mem_we;
            wait_q     <= '0;
            addr_q     <= bus.mem_addr[ADDR_W+1:2];
            be_n_q     <= ~bus.mem_be;
            ce_n_q     <= 1'b0;
            oe_n_q     <= bus.mem_we;
            we_n_q     <= ~bus.mem_we;
            wdata_oe_q <= bus.mem_we;
            if (bus.mem_we) begin
              wdata_q <= bus.mem_wdata;
            end
            state_q    <= ACC;
          end else if (bus.if_ce) begin
            owner_q <= 1'b0;
            is_wr_q <= 1'b0;
            wait_q  <= '0;
            if (buf_hit) begin
              if_rdata_q <= buf_rdata;
              if_valid_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              addr_q  <= bus.if_addr[ADDR_W+1:2];
              be_n_q  <= 4'h0;
              ce_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (!acc_last) begin
            wait_q <= wait_q + 3'd1;
          end else if (is_wr_q) begin
            // Release the write strobe one cycle before address/data for hold time.
            we_n_q  <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            if (owner_q) begin
              mem_rdata_q <= bus.sram_rdata;
              mem_done_q  <= 1'b1;
            end else begin
              if_rdata_q <= bus.sram_rdata;
              if_valid_q <= 1'b1;
            end
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            state_q <= RESP;
          end
        end
        WR_HOLD: begin
          ce_n_q     <= 1'b1;
          be_n_q     <= 4'hF;
          wdata_oe_q <= 1'b0;
          mem_done_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_rdata      = if_rdata_q;
  assign bus.if_valid      = if_valid_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.sram_ce_n     = ce_n_q;
  assign bus.sram_oe_n     = oe_n_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_be_n     = be_n_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_wdata    = wdata_q;
  assign bus.sram_wdata_oe = wdata_oe_q;

  // The pipeline stays frozen until each active requester has seen its pulse.
  assign bus.stall_req = ~rst & ((bus.mem_req & ~mem_done_q) | (bus.if_ce & ~if_valid_q));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: WAIT_CYC=1 main instance plus WAIT_CYC=0/7 latency instances.
module tb_sram_bus_arbiter;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  sram_bus_arbiter_if #(.ADDR_W(20)) bus  ();
  sram_bus_arbiter_if #(.ADDR_W(20)) bus0 ();
  sram_bus_arbiter_if #(.ADDR_W(20)) bus7 ();

  sram_bus_arbiter #(.ADDR_W(20), .WAIT_CYC(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  sram_bus_arbiter #(.ADDR_W(20), .WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_bus_arbiter #(.ADDR_W(20), .WAIT_CYC(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic test_reset;
    rst = 1'b1;
    bus.if_ce = 1'b1;
    bus.mem_req = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL rst_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
    total_cnt++; if (bus.sram_oe_n !== 1'b1) $display("FAIL rst_oe_n: got %b want 1", bus.sram_oe_n); else pass_cnt++;
    total_cnt++; if (bus.sram_we_n !== 1'b1) $display("FAIL rst_we_n: got %b want 1", bus.sram_we_n); else pass_cnt++;
    total_cnt++; if (bus.sram_be_n !== 4'hF) $display("FAIL rst_be_n: got %h want f", bus.sram_be_n); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata_oe !== 1'b0) $display("FAIL rst_wdata_oe: got %b want 0", bus.sram_wdata_oe); else pass_cnt++;
    total_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b want 0", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_done !== 1'b0) $display("FAIL rst_mem_done: got %b want 0", bus.mem_done); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h0) $display("FAIL rst_if_rdata: got %h want 0", bus.if_rdata); else pass_cnt++;
    total_cnt++; if (bus.mem_rdata !== 32'h0) $display("FAIL rst_mem_rdata: got %h want 0", bus.mem_rdata); else pass_cnt++;
    total_cnt++; if (bus.sram_addr !== 20'h0) $display("FAIL rst_sram_addr: got %h want 0", bus.sram_addr); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata !== 32'h0) $display("FAIL rst_sram_wdata: got %h want 0", bus.sram_wdata); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b0) $display("FAIL rst_stall_req: got %b want 0", bus.stall_req); else pass_cnt++;
    bus.if_ce = 1'b0;
    bus.mem_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL post_rst_idle_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
  endtask

  task automatic test_fetch;
    bus.sram_rdata = 32'h3C010001;
    bus.if_addr = 32'h80000000;
    bus.if_ce = 1'b1;
    @(negedge clk);  // cycle 1
    total_cnt++; if (bus.sram_ce_n !== 1'b0) $display("FAIL fetch_c1_ce_n: got %b want 0", bus.sram_ce_n); else pass_cnt++;
    total_cnt++; if (bus.sram_oe_n !== 1'b0) $display("FAIL fetch_c1_oe_n: got %b want 0", bus.sram_oe_n); else pass_cnt++;
    total_cnt++; if (bus.sram_be_n !== 4'h0) $display("FAIL fetch_c1_be_n: got %h want 0", bus.sram_be_n); else pass_cnt++;
    total_cnt++; if (bus.sram_addr !== 20'h0) $display("FAIL fetch_c1_addr: got %h want 0", bus.sram_addr); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b1) $display("FAIL fetch_c1_stall: got %b want 1", bus.stall_req); else pass_cnt++;
    @(negedge clk);  // cycle 2
    total_cnt++; if (bus.sram_oe_n !== 1'b0) $display("FAIL fetch_c2_oe_n: got %b want 0", bus.sram_oe_n); else pass_cnt++;
    total_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL fetch_c2_if_valid: got %b want 0", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b1) $display("FAIL fetch_c2_stall: got %b want 1", bus.stall_req); else pass_cnt++;
    @(negedge clk);  // cycle 3
    total_cnt++; if (bus.if_valid !== 1'b1) $display("FAIL fetch_c3_if_valid: got %b want 1", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h3C010001) $display("FAIL fetch_c3_if_rdata: got %h want 3c010001", bus.if_rdata); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b0) $display("FAIL fetch_c3_stall: got %b want 0", bus.stall_req); else pass_cnt++;
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL fetch_c3_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
    bus.if_ce = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL fetch_c4_if_valid: got %b want 0", bus.if_valid); else pass_cnt++;
  endtask

  task automatic test_store;
    bus.mem_addr = 32'h80000010;
    bus.mem_be = 4'b0011;
    bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_we = 1'b1;
    bus.mem_req = 1'b1;
    @(negedge clk);  // cycle 1
    total_cnt++; if (bus.sram_addr !== 20'h4) $display("FAIL store_c1_addr: got %h want 4", bus.sram_addr); else pass_cnt++;
    total_cnt++; if (bus.sram_be_n !== 4'b1100) $display("FAIL store_c1_be_n: got %b want 1100", bus.sram_be_n); else pass_cnt++;
    total_cnt++; if (bus.sram_we_n !== 1'b0) $display("FAIL store_c1_we_n: got %b want 0", bus.sram_we_n); else pass_cnt++;
    total_cnt++; if (bus.sram_oe_n !== 1'b1) $display("FAIL store_c1_oe_n: got %b want 1", bus.sram_oe_n); else pass_cnt++;
    total_cnt++; if (bus.sram_ce_n !== 1'b0) $display("FAIL store_c1_ce_n: got %b want 0", bus.sram_ce_n); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata_oe !== 1'b1) $display("FAIL store_c1_wdata_oe: got %b want 1", bus.sram_wdata_oe); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata !== 32'hDEADBEEF) $display("FAIL store_c1_wdata: got %h want deadbeef", bus.sram_wdata); else pass_cnt++;
    @(negedge clk);  // cycle 2
    total_cnt++; if (bus.sram_we_n !== 1'b0) $display("FAIL store_c2_we_n: got %b want 0", bus.sram_we_n); else pass_cnt++;
    @(negedge clk);  // cycle 3: WR_HOLD
    total_cnt++; if (bus.sram_we_n !== 1'b1) $display("FAIL store_hold_we_n: got %b want 1", bus.sram_we_n); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata_oe !== 1'b1) $display("FAIL store_hold_wdata_oe: got %b want 1", bus.sram_wdata_oe); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata !== 32'hDEADBEEF) $display("FAIL store_hold_wdata: got %h want deadbeef", bus.sram_wdata); else pass_cnt++;
    total_cnt++; if (bus.sram_addr !== 20'h4) $display("FAIL store_hold_addr: got %h want 4", bus.sram_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_done !== 1'b0) $display("FAIL store_hold_mem_done: got %b want 0", bus.mem_done); else pass_cnt++;
    @(negedge clk);  // cycle 4: RESP
    total_cnt++; if (bus.mem_done !== 1'b1) $display("FAIL store_c4_mem_done: got %b want 1", bus.mem_done); else pass_cnt++;
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL store_c4_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata_oe !== 1'b0) $display("FAIL store_c4_wdata_oe: got %b want 0", bus.sram_wdata_oe); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b0) $display("FAIL store_c4_stall: got %b want 0", bus.stall_req); else pass_cnt++;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.mem_done !== 1'b0) $display("FAIL store_c5_mem_done: got %b want 0", bus.mem_done); else pass_cnt++;
  endtask

  task automatic test_load_during_fetch;
    bus.sram_rdata = 32'h11111111;
    bus.if_addr = 32'h80000100;
    bus.if_ce = 1'b1;
    @(negedge clk);  // cycle 1: fetch in ACC
    total_cnt++; if (bus.sram_addr !== 20'h40) $display("FAIL ldf_c1_fetch_addr: got %h want 40", bus.sram_addr); else pass_cnt++;
    bus.mem_addr = 32'h80000020;
    bus.mem_be = 4'hF;
    bus.mem_we = 1'b0;
    bus.mem_req = 1'b1;
    @(negedge clk);  // cycle 2: fetch not preempted
    total_cnt++; if (bus.sram_addr !== 20'h40) $display("FAIL ldf_c2_no_preempt: got %h want 40", bus.sram_addr); else pass_cnt++;
    @(negedge clk);  // cycle 3: fetch response
    total_cnt++; if (bus.if_valid !== 1'b1) $display("FAIL ldf_c3_if_valid: got %b want 1", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h11111111) $display("FAIL ldf_c3_if_rdata: got %h want 11111111", bus.if_rdata); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b1) $display("FAIL ldf_c3_stall: got %b want 1", bus.stall_req); else pass_cnt++;
    bus.sram_rdata = 32'h22222222;
    @(negedge clk);  // cycle 4: IDLE, grant happens at end of this cycle
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL ldf_c4_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
    @(negedge clk);  // cycle 5: data ACC
    total_cnt++; if (bus.sram_addr !== 20'h8) $display("FAIL ldf_c5_data_addr: got %h want 8", bus.sram_addr); else pass_cnt++;
    total_cnt++; if (bus.sram_oe_n !== 1'b0) $display("FAIL ldf_c5_oe_n: got %b want 0", bus.sram_oe_n); else pass_cnt++;
    @(negedge clk);  // cycle 6
    @(negedge clk);  // cycle 7: load response
    total_cnt++; if (bus.mem_done !== 1'b1) $display("FAIL ldf_c7_mem_done: got %b want 1", bus.mem_done); else pass_cnt++;
    total_cnt++; if (bus.mem_rdata !== 32'h22222222) $display("FAIL ldf_c7_mem_rdata: got %h want 22222222", bus.mem_rdata); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b1) $display("FAIL ldf_c7_stall: got %b want 1", bus.stall_req); else pass_cnt++;
    bus.mem_req = 1'b0;
    bus.sram_rdata = 32'h33333333;
    @(negedge clk);  // cycle 8: IDLE, re-fetch granted
    @(negedge clk);  // cycle 9
`ifdef FETCH_BUF_EN
    total_cnt++; if (bus.if_valid !== 1'b1) $display("FAIL ldf_buf_if_valid: got %b want 1", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h11111111) $display("FAIL ldf_buf_if_rdata: got %h want 11111111", bus.if_rdata); else pass_cnt++;
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL ldf_buf_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
    bus.if_ce = 1'b0;
`else
    total_cnt++; if (bus.sram_ce_n !== 1'b0) $display("FAIL ldf_refetch_ce_n: got %b want 0", bus.sram_ce_n); else pass_cnt++;
    total_cnt++; if (bus.sram_addr !== 20'h40) $display("FAIL ldf_refetch_addr: got %h want 40", bus.sram_addr); else pass_cnt++;
    repeat (2) @(negedge clk);  // cycle 11
    total_cnt++; if (bus.if_valid !== 1'b1) $display("FAIL ldf_refetch_if_valid: got %b want 1", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h33333333) $display("FAIL ldf_refetch_if_rdata: got %h want 33333333", bus.if_rdata); else pass_cnt++;
    bus.if_ce = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_refetch_after_store;
    bus.mem_addr = 32'h80000030;
    bus.mem_be = 4'hF;
    bus.mem_wdata = 32'h0BADF00D;
    bus.mem_we = 1'b1;
    bus.mem_req = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++; if (bus.mem_done !== 1'b1) $display("FAIL ras_store_done: got %b want 1", bus.mem_done); else pass_cnt++;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.sram_rdata = 32'h44444444;
    bus.if_addr = 32'h80000100;
    bus.if_ce = 1'b1;
    @(negedge clk);  // IDLE grant cycle
    @(negedge clk);  // ACC: the buffer was invalidated by the store
    total_cnt++; if (bus.sram_ce_n !== 1'b0) $display("FAIL ras_fetch_ce_n: got %b want 0", bus.sram_ce_n); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.if_valid !== 1'b1) $display("FAIL ras_if_valid: got %b want 1", bus.if_valid); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h44444444) $display("FAIL ras_if_rdata: got %h want 44444444", bus.if_rdata); else pass_cnt++;
    bus.if_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    logic saw_done;
    bus.mem_addr = 32'h80000040;
    bus.mem_be = 4'hF;
    bus.mem_we = 1'b0;
    bus.mem_req = 1'b1;
    @(negedge clk);  // cycle 1: ACC
    total_cnt++; if (bus.sram_oe_n !== 1'b0) $display("FAIL rma_c1_oe_n: got %b want 0", bus.sram_oe_n); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.sram_ce_n !== 1'b1) $display("FAIL rma_ce_n: got %b want 1", bus.sram_ce_n); else pass_cnt++;
    total_cnt++; if (bus.sram_oe_n !== 1'b1) $display("FAIL rma_oe_n: got %b want 1", bus.sram_oe_n); else pass_cnt++;
    total_cnt++; if (bus.sram_we_n !== 1'b1) $display("FAIL rma_we_n: got %b want 1", bus.sram_we_n); else pass_cnt++;
    total_cnt++; if (bus.sram_be_n !== 4'hF) $display("FAIL rma_be_n: got %h want f", bus.sram_be_n); else pass_cnt++;
    total_cnt++; if (bus.sram_wdata_oe !== 1'b0) $display("FAIL rma_wdata_oe: got %b want 0", bus.sram_wdata_oe); else pass_cnt++;
    total_cnt++; if (bus.stall_req !== 1'b0) $display("FAIL rma_stall: got %b want 0", bus.stall_req); else pass_cnt++;
    bus.mem_req = 1'b0;
    rst = 1'b0;
    saw_done = (bus.mem_done !== 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_done !== 1'b0) saw_done = 1'b1;
    end
    total_cnt++; if (saw_done) $display("FAIL rma_no_done: got mem_done pulse want none"); else pass_cnt++;
    bus.if_addr = 32'h80000000;
    bus.sram_rdata = 32'h66666666;
    bus.if_ce = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.sram_ce_n !== 1'b0) $display("FAIL rma_idle_grant_ce_n: got %b want 0", bus.sram_ce_n); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.if_rdata !== 32'h66666666) $display("FAIL rma_refetch_rdata: got %h want 66666666", bus.if_rdata); else pass_cnt++;
    bus.if_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    int lat;
    bus0.sram_rdata = 32'h55555555;
    bus0.mem_addr = 32'h00000004;
    bus0.mem_be = 4'hF;
    bus0.mem_we = 1'b0;
    bus0.mem_req = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (bus0.mem_done === 1'b1) lat = n;
    end
    total_cnt++; if (lat != 2) $display("FAIL wait0_latency: got %0d want 2 (0 = timeout)", lat); else pass_cnt++;
    total_cnt++; if (bus0.mem_rdata !== 32'h55555555) $display("FAIL wait0_rdata: got %h want 55555555", bus0.mem_rdata); else pass_cnt++;
    bus0.mem_req = 1'b0;

    bus7.sram_rdata = 32'h77777777;
    bus7.mem_addr = 32'h00000008;
    bus7.mem_be = 4'hF;
    bus7.mem_we = 1'b0;
    bus7.mem_req = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (bus7.mem_done === 1'b1) lat = n;
    end
    total_cnt++; if (lat != 9) $display("FAIL wait7_latency: got %0d want 9 (0 = timeout)", lat); else pass_cnt++;
    total_cnt++; if (bus7.mem_rdata !== 32'h77777777) $display("FAIL wait7_rdata: got %h want 77777777", bus7.mem_rdata); else pass_cnt++;
    bus7.mem_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.if_ce = 1'b0;  bus.if_addr = '0;  bus.mem_req = 1'b0;  bus.mem_we = 1'b0;
    bus.mem_be = '0;   bus.mem_addr = '0; bus.mem_wdata = '0;  bus.sram_rdata = '0;
    bus0.if_ce = 1'b0; bus0.if_addr = '0; bus0.mem_req = 1'b0; bus0.mem_we = 1'b0;
    bus0.mem_be = '0;  bus0.mem_addr = '0; bus0.mem_wdata = '0; bus0.sram_rdata = '0;
    bus7.if_ce = 1'b0; bus7.if_addr = '0; bus7.mem_req = 1'b0; bus7.mem_we = 1'b0;
    bus7.mem_be = '0;  bus7.mem_addr = '0; bus7.mem_wdata = '0; bus7.sram_rdata = '0;

    test_reset();
    test_fetch();
    test_store();
    test_load_during_fetch();
    test_refetch_after_store();
    test_reset_mid_access();
    test_wait_states();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
